// File: rtl/ball_motion_fsm.sv
// Ball position and direction engine.
// The ball starts centred in SERVE. After SERVE_DELAY frame ticks it enters MOVE.
// In MOVE it steps SPEED pixels per axis on each frame_tick. It reflects on paddle
// and wall events from GameLogic, and it recentres and serves again after a score.
//
// Ports
//   clock        in   system clock, all state on posedge
//   reset_n      in   asynchronous active-low reset
//   frame_tick   in   one-cycle pulse per video frame
//   bounce       in   GameLogic event: 0 none, 1 paddle (x), 2 wall (y), 3 score
//   ball_pos_x   out  ball left edge, registered
//   ball_pos_y   out  ball top edge, registered
//   ball_size_x  out  constant BALL_SIZE
//   ball_size_y  out  constant BALL_SIZE
//   dir_x        out  1 = moving right (+x)
//   dir_y        out  1 = moving down (+y)
//   serving      out  1 while in SERVE
module ball_motion_fsm #(
    parameter int unsigned SCREEN_X    = 640,
    parameter int unsigned SCREEN_Y    = 480,
    parameter int unsigned BALL_SIZE   = 8,
    parameter int unsigned SPEED       = 2,
    parameter int unsigned SERVE_DELAY = 60,
    parameter int unsigned LOCKOUT     = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic [1:0] bounce,
    output logic [9:0] ball_pos_x,
    output logic [9:0] ball_pos_y,
    output logic [7:0] ball_size_x,
    output logic [7:0] ball_size_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       serving
);

    localparam int unsigned CntW  = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam int unsigned LockW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;

    localparam logic [9:0]         CenterX = 10'((SCREEN_X - BALL_SIZE) / 2);
    localparam logic [9:0]         CenterY = 10'((SCREEN_Y - BALL_SIZE) / 2);
    localparam logic signed [10:0] MaxX    = 11'(SCREEN_X - BALL_SIZE);
    localparam logic signed [10:0] MaxY    = 11'(SCREEN_Y - BALL_SIZE);
    localparam logic signed [10:0] Speed   = 11'(SPEED);

    typedef enum logic [0:0] {StServe, StMove} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   serve_cnt_q, serve_cnt_d;
    logic              pend_x_q, pend_x_d;
    logic              pend_y_q, pend_y_d;
    logic              pend_score_q, pend_score_d;
    logic [LockW-1:0]  lock_x_q, lock_x_d;
    logic [LockW-1:0]  lock_y_q, lock_y_d;
    logic [9:0]        pos_x_q, pos_x_d;
    logic [9:0]        pos_y_q, pos_y_d;
    logic              dir_x_q, dir_x_d;
    logic              dir_y_q, dir_y_d;

    // Flags seen this cycle, including an event arriving in the frame_tick cycle itself.
    logic eff_x, eff_y, eff_score;
    logic nxt_dir_x, nxt_dir_y;

    // Signed 11-bit step, saturated to the visible range. Clamping never touches direction.
    function automatic logic [9:0] step_pos(input logic [9:0] pos, input logic dir,
                                            input logic signed [10:0] max_pos);
        logic signed [10:0] p;
        p = $signed({1'b0, pos}) + (dir ? Speed : -Speed);
        if (p < 11'sd0) begin
            return 10'd0;
        end else if (p > max_pos) begin
            return max_pos[9:0];
        end else begin
            return p[9:0];
        end
    endfunction

    always_comb begin
        state_d      = state_q;
        serve_cnt_d  = serve_cnt_q;
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        pend_score_d = pend_score_q;
        lock_x_d     = lock_x_q;
        lock_y_d     = lock_y_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;
        nxt_dir_x    = dir_x_q;
        nxt_dir_y    = dir_y_q;
        eff_x        = pend_x_q | (bounce == 2'd1);
        eff_y        = pend_y_q | (bounce == 2'd2);
        eff_score    = pend_score_q | (bounce == 2'd3);

        unique case (state_q)
            StServe: begin
                // Events are ignored while serving.
                pend_x_d     = 1'b0;
                pend_y_d     = 1'b0;
                pend_score_d = 1'b0;
                if (frame_tick) begin
                    if (serve_cnt_q == CntW'(SERVE_DELAY - 1)) begin
                        state_d     = StMove;
                        serve_cnt_d = '0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + CntW'(1);
                    end
                end
            end
            StMove: begin
                pend_x_d     = eff_x;
                pend_y_d     = eff_y;
                pend_score_d = eff_score;
                if (frame_tick) begin
                    pend_x_d     = 1'b0;
                    pend_y_d     = 1'b0;
                    pend_score_d = 1'b0;
                    if (eff_score) begin
                        state_d     = StServe;
                        serve_cnt_d = '0;
                        pos_x_d     = CenterX;
                        pos_y_d     = CenterY;
                        dir_x_d     = ~dir_x_q;
                        lock_x_d    = '0;
                        lock_y_d    = '0;
                    end else begin
                        // A freshly loaded lock skips this tick's decrement.
                        if (eff_x && (lock_x_q == '0)) begin
                            nxt_dir_x = ~dir_x_q;
                            lock_x_d  = LockW'(LOCKOUT);
                        end else if (lock_x_q != '0) begin
                            lock_x_d = lock_x_q - LockW'(1);
                        end
                        if (eff_y && (lock_y_q == '0)) begin
                            nxt_dir_y = ~dir_y_q;
                            lock_y_d  = LockW'(LOCKOUT);
                        end else if (lock_y_q != '0) begin
                            lock_y_d = lock_y_q - LockW'(1);
                        end
                        dir_x_d = nxt_dir_x;
                        dir_y_d = nxt_dir_y;
                        pos_x_d = step_pos(pos_x_q, nxt_dir_x, MaxX);
                        pos_y_d = step_pos(pos_y_q, nxt_dir_y, MaxY);
                    end
                end
            end
            default: state_d = StServe;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StServe;
            serve_cnt_q  <= '0;
            pend_x_q     <= 1'b0;
            pend_y_q     <= 1'b0;
            pend_score_q <= 1'b0;
            lock_x_q     <= '0;
            lock_y_q     <= '0;
            pos_x_q      <= CenterX;
            pos_y_q      <= CenterY;
            dir_x_q      <= 1'b1;
            dir_y_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            serve_cnt_q  <= serve_cnt_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pend_score_q <= pend_score_d;
            lock_x_q     <= lock_x_d;
            lock_y_q     <= lock_y_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
        end
    end

    assign ball_pos_x  = pos_x_q;
    assign ball_pos_y  = pos_y_q;
    assign ball_size_x = 8'(BALL_SIZE);
    assign ball_size_y = 8'(BALL_SIZE);
    assign dir_x       = dir_x_q;
    assign dir_y       = dir_y_q;
    assign serving     = (state_q == StServe);

endmodule

// File: tb/tb_ball_motion_fsm.sv
// Testbench for ball_motion_fsm (SERVE_DELAY overridden to 4).
// The stimulus side queues the expected state for every frame tick or explicit check.
// A monitor pops and compares one cycle after each tick or check.
module tb_ball_motion_fsm;

    logic       clock      = 1'b0;
    logic       reset_n    = 1'b0;
    logic       frame_tick = 1'b0;
    logic       check_req  = 1'b0;
    logic [1:0] bounce     = 2'd0;
    logic [9:0] ball_pos_x, ball_pos_y;
    logic [7:0] ball_size_x, ball_size_y;
    logic       dir_x, dir_y, serving;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    typedef struct {
        string      name;
        logic [9:0] px;
        logic [9:0] py;
        logic       dx;
        logic       dy;
        logic       sv;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    ball_motion_fsm #(
        .SCREEN_X   (640),
        .SCREEN_Y   (480),
        .BALL_SIZE  (8),
        .SPEED      (2),
        .SERVE_DELAY(4),
        .LOCKOUT    (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .bounce     (bounce),
        .ball_pos_x (ball_pos_x),
        .ball_pos_y (ball_pos_y),
        .ball_size_x(ball_size_x),
        .ball_size_y(ball_size_y),
        .dir_x      (dir_x),
        .dir_y      (dir_y),
        .serving    (serving)
    );

    always #5 clock = ~clock;

    // Monitor: outputs are due the cycle after a tick or check request.
    always @(posedge clock) begin
        if (frame_tick || check_req) begin
            #1;
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_sample: got x=%0d y=%0d, required no sample",
                         ball_pos_x, ball_pos_y);
            end else begin
                mon_e = exp_q.pop_front();
                if (ball_pos_x !== mon_e.px || ball_pos_y !== mon_e.py || dir_x !== mon_e.dx ||
                    dir_y !== mon_e.dy || serving !== mon_e.sv || ball_size_x !== 8'd8 ||
                    ball_size_y !== 8'd8) begin
                    nerr++;
                    $display({"FAIL %s: got x=%0d y=%0d dx=%0b dy=%0b srv=%0b sz=%0d/%0d, ",
                              "required x=%0d y=%0d dx=%0b dy=%0b srv=%0b sz=8/8"},
                             mon_e.name, ball_pos_x, ball_pos_y, dir_x, dir_y, serving,
                             ball_size_x, ball_size_y, mon_e.px, mon_e.py, mon_e.dx, mon_e.dy,
                             mon_e.sv);
                end
            end
        end
    end

    task automatic push(input string n, input int px, input int py, input bit dx, input bit dy,
                        input bit sv);
        exp_t e;
        e.name = n;
        e.px   = 10'(px);
        e.py   = 10'(py);
        e.dx   = dx;
        e.dy   = dy;
        e.sv   = sv;
        exp_q.push_back(e);
    endtask

    task automatic tick(input string n, input int px, input int py, input bit dx, input bit dy,
                        input bit sv);
        @(negedge clock);
        frame_tick = 1'b1;
        push(n, px, py, dx, dy, sv);
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    task automatic chk(input string n, input int px, input int py, input bit dx, input bit dy,
                       input bit sv);
        @(negedge clock);
        check_req = 1'b1;
        push(n, px, py, dx, dy, sv);
        @(negedge clock);
        check_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse(input logic [1:0] v);
        @(negedge clock);
        bounce = v;
        @(negedge clock);
        bounce = 2'd0;
    endtask

    initial begin
        int y;
        int waited;
        // Reset state, sampled while reset is still asserted.
        chk("reset_hold", 316, 236, 1'b1, 1'b1, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;
        idle(2);

        // Serve for 4 ticks; a bounce during serve is ignored.
        tick("serve1", 316, 236, 1'b1, 1'b1, 1'b1);
        pulse(2'd1);
        tick("serve2", 316, 236, 1'b1, 1'b1, 1'b1);
        tick("serve3", 316, 236, 1'b1, 1'b1, 1'b1);
        tick("serve4", 316, 236, 1'b1, 1'b1, 1'b0);
        tick("move1", 318, 238, 1'b1, 1'b1, 1'b0);

        // Single wall event between ticks.
        idle(2);
        pulse(2'd2);
        idle(1);
        tick("ybounce", 320, 236, 1'b1, 1'b0, 1'b0);
        tick("ylock1", 322, 234, 1'b1, 1'b0, 1'b0);
        tick("ylock2", 324, 232, 1'b1, 1'b0, 1'b0);

        // Wall event held over three ticks gives one flip.
        @(negedge clock);
        bounce = 2'd2;
        idle(1);
        tick("hold1", 326, 234, 1'b1, 1'b1, 1'b0);
        idle(2);
        tick("hold2", 328, 236, 1'b1, 1'b1, 1'b0);
        idle(2);
        tick("hold3", 330, 238, 1'b1, 1'b1, 1'b0);
        bounce = 2'd0;
        idle(2);
        tick("hold_after", 332, 240, 1'b1, 1'b1, 1'b0);

        // Paddle and wall in one frame flip both axes.
        pulse(2'd1);
        idle(1);
        pulse(2'd2);
        tick("both", 330, 238, 1'b0, 1'b0, 1'b0);
        tick("drain1", 328, 236, 1'b0, 1'b0, 1'b0);
        tick("drain2", 326, 234, 1'b0, 1'b0, 1'b0);

        // A score wins over x/y events in the same frame.
        pulse(2'd1);
        pulse(2'd2);
        pulse(2'd3);
        tick("score", 316, 236, 1'b1, 1'b0, 1'b1);
        pulse(2'd1);
        tick("reserve1", 316, 236, 1'b1, 1'b0, 1'b1);
        pulse(2'd3);
        tick("reserve2", 316, 236, 1'b1, 1'b0, 1'b1);
        pulse(2'd2);
        tick("reserve3", 316, 236, 1'b1, 1'b0, 1'b1);
        tick("reserve4", 316, 236, 1'b1, 1'b0, 1'b0);
        tick("move2", 318, 234, 1'b1, 1'b0, 1'b0);

        // Head down to the bottom edge and saturate at 472.
        pulse(2'd2);
        tick("yflip2", 320, 236, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 119; k++) begin
            y = 236 + 2 * k;
            if (y > 472) y = 472;
            tick("climb", 320 + 2 * k, y, 1'b1, 1'b1, 1'b0);
        end

        // Asynchronous reset in the middle of a cycle while moving.
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        chk("async_reset", 316, 236, 1'b1, 1'b1, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;
        idle(20);
        chk("hold_idle", 316, 236, 1'b1, 1'b1, 1'b1);

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (exp_q.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
